datamem_arbiter: RTL
====================

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one datamem port (2..8).
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, N_REQ: bit i high = requester i has an access pending.
REQ-005 SHALL have port req_we, input, N_REQ: bit i high = requester i's access is a write.
REQ-006 SHALL have port req_addr, input, N_REQ*`DATAMEM_ADDR_WIDTH: requester i's address in slice i.
REQ-007 SHALL have port req_wdata, input, N_REQ*`DATA_WORD_LENGTH: requester i's write data in slice i.
REQ-008 SHALL have port ack, output, N_REQ: one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rdata, output, `DATA_WORD_LENGTH: read data, valid while ack is high.
REQ-010 SHALL have port busy, output, 1: high while state is not IDLE.
REQ-011 SHALL have ports mem_we, mem_addr and mem_wdata, outputs, widths 1, `DATAMEM_ADDR_WIDTH and `DATA_WORD_LENGTH: drive datamem MemWrite, Address and WriteData.
REQ-012 SHALL have port mem_rdata, input, `DATA_WORD_LENGTH: datamem ReadData (combinational read).

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and RESP; transitions: IDLE->ACCESS when any req bit is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 SHALL, in IDLE with req nonzero, select the winner round-robin: the first set req bit found scanning from index ptr upward, wrapping modulo N_REQ.
REQ-015 SHALL, on the IDLE->ACCESS edge, latch the winner index, req_we[win], req_addr slice win and req_wdata slice win, and set ptr to (win+1) mod N_REQ.
REQ-016 SHALL, during ACCESS only, drive mem_addr and mem_wdata from the latched values and mem_we from the latched we; outside ACCESS, mem_we SHALL be 0, with mem_addr and mem_wdata held at their last latched values.
REQ-017 SHALL, on the ACCESS->RESP edge, register mem_rdata into rdata for both reads and writes and set ack[win]=1 with all other ack bits 0.
REQ-018 SHALL hold ack high for exactly the RESP cycle; ack SHALL be all-zero in every other state.
REQ-019 SHALL hold rdata until the next ACCESS->RESP edge.
REQ-020 SHALL give, per access, req sampled at edge E -> memory write committed at E+1 -> ack visible in the cycle between E+1 and E+2; sustained throughput is one access per 3 cycles.
REQ-021 SHALL require a requester to hold req and its fields stable until it sees ack, then deassert req or present a new request on the following edge; the arbiter SHALL NOT sample req in RESP.
REQ-022 SHALL complete an access using latched values if the winner drops req during ACCESS or RESP; ack SHALL still be issued.
REQ-023 SHALL ignore req bits that rise during ACCESS or RESP until the next IDLE cycle.
REQ-024 SHALL pass addresses at full width; truncation is the memory's responsibility.
REQ-025 SHALL make win and ptr ceil(log2(N_REQ)) bits, with the wrap computed modulo N_REQ for non-power-of-two N_REQ.

Reset
REQ-026 SHALL, while reset_n is low, force state=IDLE, ptr=0, ack=0, rdata=0, busy=0, mem_we=0, mem_addr=0 and mem_wdata=0 asynchronously.
REQ-027 SHALL treat reset asserted during ACCESS as an abort: mem_we drops immediately, the write is not committed if reset is low at the edge, and no ack is issued.
REQ-028 SHALL, after reset_n rises, first arbitrate at the following rising edge with ptr=0.

Verification
REQ-029 SHALL verify single write: req=0001, we=1, addr=5, wdata=0xA5 -> mem_we=1 with addr 5 for one cycle, ack=0001 two cycles after the sampling edge, RAM[5]=0xA5.
REQ-030 SHALL verify single read: after the write above, requester 2 reads addr 5 -> ack=0100, rdata=0xA5.
REQ-031 SHALL verify fairness: req=1111 held, each requester re-requesting right after its ack -> grant order 0,1,2,3,0,1 with one ack every 3 cycles.
REQ-032 SHALL verify pointer wrap: ptr=3 (after serving requester 2), req=1001 -> requester 3 first, then requester 0.
REQ-033 SHALL verify drop and late arrival: the winner drops req in ACCESS -> ack still issued; req bit 1 rising in RESP -> served only from the next IDLE.
REQ-034 SHALL verify reset during a write ACCESS: reset_n low mid-cycle -> mem_we=0 at once, RAM unchanged, ack=0, state=IDLE.

Source files
------------

// File: rtl/datamem_arbiter.sv
`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 32
`endif
`default_nettype none
// ============================================================================
// datamem_arbiter : round-robin sharing of one datamem port among N_REQ users
// Revision 1.0
// ============================================================================
module datamem_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [N_REQ-1:0]                      req,
  input  logic [N_REQ-1:0]                      req_we,
  input  logic [N_REQ*`DATAMEM_ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_REQ*`DATA_WORD_LENGTH-1:0]    req_wdata,
  output logic [N_REQ-1:0]                      ack,
  output logic [`DATA_WORD_LENGTH-1:0]          rdata,
  output logic                                  busy,
  output logic                                  mem_we,
  output logic [`DATAMEM_ADDR_WIDTH-1:0]        mem_addr,
  output logic [`DATA_WORD_LENGTH-1:0]          mem_wdata,
  input  logic [`DATA_WORD_LENGTH-1:0]          mem_rdata
);
  localparam int AW = `DATAMEM_ADDR_WIDTH;
  localparam int DW = `DATA_WORD_LENGTH;
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [PW:0]     scan;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   pick;
  logic            found;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // Scan upward from ptr with an explicit modulo so non-power-of-two N_REQ wraps correctly.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan     = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan >= (PW+1)'(N_REQ)) begin
        scan = scan - (PW+1)'(N_REQ);
      end
      scan_idx = scan[PW-1:0];
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == PW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACCESS;
          win_d   = pick;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          ptr_d   = (pick == PW'(N_REQ-1)) ? '0 : pick + PW'(1);
        end
      end
      ACCESS: begin
        state_d       = RESP;
        rdata_d       = mem_rdata;
        ack_d[win_q]  = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // mem_we is gated by state so an asynchronous reset in ACCESS kills the write at once.
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
